// File: rtl/ma_peak_detect.sv
// Threshold-crossing peak search on the averaged correlation magnitude: tracks the maximum of
// each above-threshold run, reports peak/index/width one clock after the run ends, then holds off.
module ma_peak_detect #(
  parameter int DATA_W    = 71,
  parameter int IDX_W     = 16,
  parameter int MIN_WIDTH = 2,
  parameter int MAX_RUN   = 1024,
  parameter int HOLDOFF   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] din,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     det_valid,
  output logic signed [DATA_W-1:0] det_peak,
  output logic [IDX_W-1:0]         det_idx,
  output logic [IDX_W-1:0]         det_width,
  output logic [7:0]               det_count,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] MIN_W_C   = IDX_W'(MIN_WIDTH);
  localparam logic [IDX_W-1:0] MAX_RUN_C = IDX_W'(MAX_RUN);
  localparam logic [IDX_W-1:0] HOLD_C    = IDX_W'(HOLDOFF);
  localparam logic [IDX_W-1:0] ONE_C     = IDX_W'(1);

  // With no holdoff window a report drops straight back to searching.
  localparam state_t POST_STATE = (HOLDOFF == 0) ? S_IDLE : S_HOLD;

  state_t                     state, state_n;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           run, run_n;
  logic [IDX_W-1:0]           peak_idx, peak_idx_n;
  logic [IDX_W-1:0]           hold_cnt, hold_n;
  logic signed [DATA_W-1:0]   peak, peak_n;

  logic                       above;
  logic                       report;
  logic signed [DATA_W-1:0]   rep_peak;
  logic [IDX_W-1:0]           rep_idx;
  logic [IDX_W-1:0]           rep_width;

  assign above = (din > threshold);

  always_comb begin
    state_n    = state;
    run_n      = run;
    peak_n     = peak;
    peak_idx_n = peak_idx;
    hold_n     = hold_cnt;
    report     = 1'b0;
    rep_peak   = peak;
    rep_idx    = peak_idx;
    rep_width  = run;

    if (en) begin
      case (state)
        S_IDLE: begin
          if (above) begin
            state_n    = S_TRACK;
            run_n      = ONE_C;
            peak_n     = din;
            peak_idx_n = idx;
            // A single-sample run already reaches the forced-report length.
            if (MAX_RUN_C == ONE_C) begin
              report    = 1'b1;
              rep_peak  = din;
              rep_idx   = idx;
              rep_width = ONE_C;
              state_n   = POST_STATE;
              hold_n    = HOLD_C;
            end
          end
        end

        S_TRACK: begin
          if (above) begin
            run_n = run + ONE_C;
            if (din > peak) begin
              peak_n     = din;
              peak_idx_n = idx;
            end
            if (run_n == MAX_RUN_C) begin
              report    = 1'b1;
              rep_peak  = peak_n;
              rep_idx   = peak_idx_n;
              rep_width = run_n;
              state_n   = POST_STATE;
              hold_n    = HOLD_C;
            end
          end else if (run >= MIN_W_C) begin
            report  = 1'b1;
            state_n = POST_STATE;
            hold_n  = HOLD_C;
          end else begin
            state_n = S_IDLE;
          end
        end

        S_HOLD: begin
          if (hold_cnt <= ONE_C) begin
            hold_n  = '0;
            state_n = S_IDLE;
          end else begin
            hold_n = hold_cnt - ONE_C;
          end
        end

        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      run       <= '0;
      peak      <= '0;
      peak_idx  <= '0;
      hold_cnt  <= '0;
      det_valid <= 1'b0;
      det_peak  <= '0;
      det_idx   <= '0;
      det_width <= '0;
      det_count <= '0;
      busy      <= 1'b0;
    end else if (clear) begin
      // Last report fields stay visible across a soft clear.
      state     <= S_IDLE;
      idx       <= '0;
      run       <= '0;
      hold_cnt  <= '0;
      det_valid <= 1'b0;
      det_count <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      run       <= run_n;
      peak      <= peak_n;
      peak_idx  <= peak_idx_n;
      hold_cnt  <= hold_n;
      det_valid <= report;
      busy      <= (state_n != S_IDLE);
      if (en) begin
        idx <= idx + ONE_C;
      end
      if (report) begin
        det_peak  <= rep_peak;
        det_idx   <= rep_idx;
        det_width <= rep_width;
        det_count <= det_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ma_peak_detect.sv
// Self-checking bench for ma_peak_detect: table of per-sample vectors with a report scoreboard,
// plus hand sequences for soft clear and asynchronous reset in the middle of a run.
module tb_ma_peak_detect;

  localparam int DW = 71;
  localparam int IW = 16;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 clear;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] threshold;

  logic                 d_valid, z_valid;
  logic signed [DW-1:0] d_peak, z_peak;
  logic [IW-1:0]        d_idx, z_idx, d_width, z_width;
  logic [7:0]           d_count, z_count;
  logic                 d_busy, z_busy;

  logic                 sel;
  logic                 o_valid, o_busy;
  logic signed [DW-1:0] o_peak;
  logic [IW-1:0]        o_idx, o_width;
  logic [7:0]           o_count;

  ma_peak_detect #(.DATA_W(DW), .IDX_W(IW), .MIN_WIDTH(2), .MAX_RUN(8), .HOLDOFF(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .din(din), .threshold(threshold),
    .det_valid(d_valid), .det_peak(d_peak), .det_idx(d_idx), .det_width(d_width),
    .det_count(d_count), .busy(d_busy)
  );

  ma_peak_detect #(.DATA_W(DW), .IDX_W(IW), .MIN_WIDTH(2), .MAX_RUN(8), .HOLDOFF(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .din(din), .threshold(threshold),
    .det_valid(z_valid), .det_peak(z_peak), .det_idx(z_idx), .det_width(z_width),
    .det_count(z_count), .busy(z_busy)
  );

  assign o_valid = sel ? z_valid : d_valid;
  assign o_peak  = sel ? z_peak  : d_peak;
  assign o_idx   = sel ? z_idx   : d_idx;
  assign o_width = sel ? z_width : d_width;
  assign o_count = sel ? z_count : d_count;
  assign o_busy  = sel ? z_busy  : d_busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic   en;
    logic   clr;
    longint din;
    longint thr;
    logic   busy;
    logic   rep;
    longint pk;
    int     pidx;
    int     wid;
  } vec_t;

  typedef struct {
    logic signed [DW-1:0] pk;
    logic [IW-1:0]        pidx;
    logic [IW-1:0]        wid;
    logic [7:0]           cnt;
  } rep_t;

  vec_t tab_a[$];
  vec_t tab_b[$];
  rep_t sb[$];
  int   n_tests;
  int   n_fail;
  int   exp_cnt;

  function automatic vec_t mk(logic e, logic c, longint d, longint t, logic b,
                              logic r, longint pk, int pi, int w);
    vec_t v;
    v.en = e; v.clr = c; v.din = d; v.thr = t; v.busy = b;
    v.rep = r; v.pk = pk; v.pidx = pi; v.wid = w;
    return v;
  endfunction

  function automatic vec_t s(longint d, longint t, logic b);
    return mk(1'b1, 1'b0, d, t, b, 1'b0, 0, 0, 0);
  endfunction

  function automatic vec_t r(longint d, longint t, logic b, longint pk, int pi, int w);
    return mk(1'b1, 1'b0, d, t, b, 1'b1, pk, pi, w);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Four ignored samples of a HOLDOFF=4 window, then back to IDLE.
  task automatic add_hold(input longint d, input longint t);
    for (int i = 0; i < 4; i++) tab_a.push_back(s(d, t, (i < 3)));
  endtask

  task automatic step(input vec_t v);
    rep_t e;
    rep_t g;
    en        = v.en;
    clear     = v.clr;
    din       = v.din;
    threshold = v.thr;
    if (v.clr) exp_cnt = 0;
    if (v.rep) begin
      exp_cnt++;
      e.pk   = v.pk;
      e.pidx = IW'(v.pidx);
      e.wid  = IW'(v.wid);
      e.cnt  = 8'(exp_cnt);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("det_valid", o_valid, v.rep);
    if (o_valid && sb.size() > 0) begin
      g = sb.pop_front();
      chk("det_peak",  o_peak,  g.pk);
      chk("det_idx",   o_idx,   g.pidx);
      chk("det_width", o_width, g.wid);
      chk("det_count", o_count, g.cnt);
    end
    chk("busy", o_busy, v.busy);
    en    = 1'b0;
    clear = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_peak"},  o_peak,  0);
    chk({tag, "_idx"},   o_idx,   0);
    chk({tag, "_width"}, o_width, 0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_busy"},  o_busy,  0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_cnt = 0; sel = 1'b0;
    rst = 1'b1; en = 1'b0; clear = 1'b0; din = '0; threshold = '0;

    // Single run, holdoff rejection, then a detection once the window expires.
    tab_a.push_back(s(0, 100, 0));
    tab_a.push_back(s(0, 100, 0));
    tab_a.push_back(s(150, 100, 1));
    tab_a.push_back(s(300, 100, 1));
    tab_a.push_back(s(200, 100, 1));
    tab_a.push_back(r(50, 100, 1, 300, 3, 3));
    tab_a.push_back(s(0, 100, 1));
    tab_a.push_back(s(200, 100, 1));
    tab_a.push_back(s(200, 100, 1));
    tab_a.push_back(s(0, 100, 0));
    tab_a.push_back(s(250, 100, 1));
    tab_a.push_back(s(120, 100, 1));
    tab_a.push_back(r(0, 100, 1, 250, 10, 2));
    add_hold(0, 100);
    // Glitch rejection, then a tie that must keep the earlier index.
    tab_a.push_back(s(0, 100, 0));
    tab_a.push_back(s(150, 100, 1));
    tab_a.push_back(s(0, 100, 0));
    tab_a.push_back(s(300, 100, 1));
    tab_a.push_back(s(300, 100, 1));
    tab_a.push_back(r(0, 100, 1, 300, 20, 2));
    add_hold(0, 100);
    // Run with en gaps, including gaps inside the holdoff window.
    tab_a.push_back(s(150, 100, 1));
    tab_a.push_back(mk(1'b0, 1'b0, 999, 100, 1, 1'b0, 0, 0, 0));
    tab_a.push_back(s(300, 100, 1));
    tab_a.push_back(mk(1'b0, 1'b0, 0, 100, 1, 1'b0, 0, 0, 0));
    tab_a.push_back(s(200, 100, 1));
    tab_a.push_back(mk(1'b0, 1'b0, 0, 100, 1, 1'b0, 0, 0, 0));
    tab_a.push_back(r(50, 100, 1, 300, 28, 3));
    tab_a.push_back(mk(1'b0, 1'b0, 0, 100, 1, 1'b0, 0, 0, 0));
    tab_a.push_back(s(0, 100, 1));
    tab_a.push_back(mk(1'b0, 1'b0, 0, 100, 1, 1'b0, 0, 0, 0));
    tab_a.push_back(s(0, 100, 1));
    tab_a.push_back(s(0, 100, 1));
    tab_a.push_back(s(0, 100, 0));
    // Signed compare with a negative threshold.
    tab_a.push_back(s(-60, -50, 0));
    tab_a.push_back(s(-40, -50, 1));
    tab_a.push_back(s(-10, -50, 1));
    tab_a.push_back(r(-70, -50, 1, -10, 37, 2));
    add_hold(0, -50);
    // Forced report at MAX_RUN=8 while still above threshold.
    for (int i = 0; i < 7; i++) tab_a.push_back(s(500, 100, 1));
    tab_a.push_back(r(500, 100, 1, 500, 43, 8));
    add_hold(500, 100);
    tab_a.push_back(s(0, 100, 0));
    tab_a.push_back(s(500, 100, 1));
    tab_a.push_back(s(600, 100, 1));
    tab_a.push_back(r(0, 100, 1, 600, 57, 2));
    add_hold(0, 100);
    tab_a.push_back(s(500, 100, 1));
    tab_a.push_back(s(600, 100, 1));

    // HOLDOFF=0 instance: back-to-back runs split by one low sample.
    tab_b.push_back(s(200, 100, 1));
    tab_b.push_back(s(200, 100, 1));
    tab_b.push_back(r(0, 100, 0, 200, 0, 2));
    tab_b.push_back(s(300, 100, 1));
    tab_b.push_back(s(150, 100, 1));
    tab_b.push_back(r(0, 100, 0, 300, 3, 2));

    #22;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tab_a[i]) step(tab_a[i]);

    // Soft clear mid-run: counters cleared, last report retained.
    step(mk(1'b1, 1'b1, 0, 100, 0, 1'b0, 0, 0, 0));
    chk("clear_count", o_count, 0);
    chk("clear_peak",  o_peak,  600);
    chk("clear_idx",   o_idx,   57);
    chk("clear_width", o_width, 2);

    sel = 1'b1;
    foreach (tab_b[i]) step(tab_b[i]);
    step(mk(1'b0, 1'b1, 0, 100, 0, 1'b0, 0, 0, 0));
    sel = 1'b0;

    // Asynchronous reset in the middle of a run: outputs drop before any clock edge.
    step(s(200, 100, 1));
    step(s(300, 100, 1));
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    step(s(0, 100, 0));
    step(s(200, 100, 1));
    step(s(200, 100, 1));
    step(r(0, 100, 1, 200, 1, 2));

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
